// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB arbiter: MASNUM masters, per-master priority, fixed or
// round-robin tie-break, burst-aware re-arbitration, locked-transfer hold and
// a beat limit for undefined-length INCR bursts.
module ahb_arbiter_param #(
    parameter int unsigned MASNUM         = 4,
    parameter int unsigned PRIOW          = 2,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_HOLD       = 16
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [MASNUM-1:0]         hbusreq,
    input  logic [MASNUM-1:0]         hlock,
    input  logic [MASNUM*PRIOW-1:0]   hprior,
    input  logic                      rr_mode,
    input  logic [1:0]                htrans,
    input  logic [2:0]                hburst,
    input  logic                      hready,
    output logic [MASNUM-1:0]         hgrant,
    output logic [$clog2(MASNUM)-1:0] hmaster,
    output logic [$clog2(MASNUM)-1:0] hmaster_d,
    output logic                      hmastlock
);

    localparam int unsigned MW = $clog2(MASNUM);
    localparam int unsigned HW = $clog2(MAX_HOLD);
    localparam logic [MW-1:0] DEF = MW'(DEFAULT_MASTER);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_LOCKED} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   own_q, own_d;
    logic [MW-1:0]   dph_q, dph_d;
    logic [MW-1:0]   rr_q, rr_d;
    logic            lock_q, lock_d;
    logic [4:0]      rem_q, rem_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic            acc, nonseq, is_incr, last_fixed, hold_hit, arb_pt, keep;
    logic [4:0]      blen, rem_cur;
    logic [HW-1:0]   hold_cur;
    logic [PRIOW-1:0] best_pri;
    logic [MW-1:0]   winner;
    int unsigned     key, best_key;

    // Beat tracking: remaining beats of fixed bursts, beat count of INCR bursts.
    always_comb begin
        acc        = hready && htrans[1];
        nonseq     = (htrans == 2'b10);
        is_incr    = (hburst == 3'b001);
        unique case (hburst[2:1])
            2'b00:   blen = 5'd1;
            2'b01:   blen = 5'd4;
            2'b10:   blen = 5'd8;
            default: blen = 5'd16;
        endcase
        // A NONSEQ restarts both counters before counting itself.
        rem_cur    = nonseq ? blen : rem_q;
        hold_cur   = nonseq ? '0 : hold_q;
        rem_d      = rem_q;
        hold_d     = hold_q;
        last_fixed = 1'b0;
        hold_hit   = 1'b0;
        if (acc) begin
            if (is_incr) begin
                hold_hit = (hold_cur == HW'(MAX_HOLD - 1));
                hold_d   = hold_hit ? '0 : hold_cur + 1'b1;
                rem_d    = '0;
            end else begin
                last_fixed = (rem_cur <= 5'd1);
                rem_d      = (rem_cur == '0) ? '0 : rem_cur - 1'b1;
                hold_d     = hold_cur;
            end
        end
        arb_pt = hready && ((htrans == 2'b00) || last_fixed || hold_hit);
    end

    // Winner: highest priority among requesters, ties by index or rotating order.
    always_comb begin
        best_pri = '0;
        for (int unsigned i = 0; i < MASNUM; i++) begin
            if (hbusreq[i] && (hprior[i*PRIOW +: PRIOW] > best_pri)) begin
                best_pri = hprior[i*PRIOW +: PRIOW];
            end
        end
        // Round-robin key is the distance past the pointer, so the pointer's own
        // index ranks last among tied masters.
        winner   = DEF;
        best_key = MASNUM;
        key      = 0;
        for (int unsigned i = 0; i < MASNUM; i++) begin
            key = i + MASNUM - 1 - 32'(rr_q);
            if (key >= MASNUM) begin
                key = key - MASNUM;
            end
            if (!rr_mode) begin
                key = i;
            end
            if (hbusreq[i] && (hprior[i*PRIOW +: PRIOW] == best_pri) && (key < best_key)) begin
                best_key = key;
                winner   = MW'(i);
            end
        end
    end

    // Ownership FSM: re-arbitrate only at arbitration points unless locked.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        dph_d   = hready ? own_q : dph_q;
        keep    = (state_q == ST_LOCKED) || hlock[own_q];
        if (arb_pt) begin
            own_d = keep ? own_q : winner;
            if (own_d != own_q) begin
                rr_d = own_d;
            end
            lock_d = hlock[own_d];
            if (hlock[own_d]) begin
                state_d = ST_LOCKED;
            end else if (!keep && !(|hbusreq)) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_OWN;
            end
        end else if (hready && (state_q == ST_LOCKED)) begin
            lock_d = hlock[own_q];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state_q <= ST_IDLE;
            own_q   <= DEF;
            dph_q   <= DEF;
            rr_q    <= DEF;
            lock_q  <= 1'b0;
            rem_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            dph_q   <= dph_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            rem_q   <= rem_d;
            hold_q  <= hold_d;
        end
    end

    // Output decode: grant is one-hot of the registered owner.
    always_comb begin
        hgrant        = '0;
        hgrant[own_q] = 1'b1;
        hmaster       = own_q;
        hmaster_d     = dph_q;
        hmastlock     = lock_q;
    end

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Self-checking bench for ahb_arbiter_param (4 masters, MAX_HOLD=4).
module tb_ahb_arbiter_param;

    localparam int NM       = 4;
    localparam int DEF      = 0;
    localparam int MAX_HOLD = 4;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic       hclk;
    logic       hreset_n;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [7:0] hprior;
    logic       rr_mode;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_d;
    logic       hmastlock;

    int checks = 0;
    int errors = 0;

    ahb_arbiter_param #(
        .MASNUM(4),
        .PRIOW(2),
        .DEFAULT_MASTER(0),
        .MAX_HOLD(4)
    ) dut (
        .hclk(hclk),
        .hreset_n(hreset_n),
        .hbusreq(hbusreq),
        .hlock(hlock),
        .hprior(hprior),
        .rr_mode(rr_mode),
        .htrans(htrans),
        .hburst(hburst),
        .hready(hready),
        .hgrant(hgrant),
        .hmaster(hmaster),
        .hmaster_d(hmaster_d),
        .hmastlock(hmastlock)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_owner, m_dph, m_rr, m_left, m_beats, m_next;
    bit  m_lock, m_locked, m_arb;
    bit  m_valid = 1'b0;

    function automatic bit bit_of(input logic [3:0] v, input int i);
        return ((v >> i) & 4'd1) != 4'd0;
    endfunction

    function automatic int pri_of(input int i);
        return int'((hprior >> (2 * i)) & 8'h03);
    endfunction

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'b000:         return 1;
            3'b001:         return 0;
            3'b010, 3'b011: return 4;
            3'b100, 3'b101: return 8;
            default:        return 16;
        endcase
    endfunction

    function automatic int pick();
        int best = -1;
        for (int i = 0; i < NM; i++)
            if (bit_of(hbusreq, i) && pri_of(i) > best) best = pri_of(i);
        if (best < 0) return DEF;
        for (int k = 1; k <= NM; k++) begin
            int m = rr_mode ? (m_rr + k) % NM : k - 1;
            if (bit_of(hbusreq, m) && pri_of(m) == best) return m;
        end
        return DEF;
    endfunction

    always @(posedge hclk) begin
        if (!hreset_n) begin
            m_owner  = DEF;
            m_dph    = DEF;
            m_rr     = DEF;
            m_lock   = 1'b0;
            m_locked = 1'b0;
            m_left   = 0;
            m_beats  = 0;
            m_valid  = 1'b1;
        end else if (hready) begin
            m_arb = (htrans == T_IDLE);
            m_dph = m_owner;
            if (htrans[1]) begin
                if (htrans == T_NONSEQ) begin
                    m_beats = 0;
                    m_left  = burst_len(hburst);
                end
                if (hburst == 3'b001) begin
                    m_beats++;
                    if (m_beats % MAX_HOLD == 0) m_arb = 1'b1;
                end else begin
                    if (m_left > 0) m_left--;
                    if (m_left == 0) m_arb = 1'b1;
                end
            end
            if (m_arb) begin
                if (!(m_locked || bit_of(hlock, m_owner))) begin
                    m_next = pick();
                    if (m_next != m_owner) begin
                        m_owner = m_next;
                        m_rr    = m_next;
                    end
                end
                m_locked = bit_of(hlock, m_owner);
                m_lock   = m_locked;
            end else if (m_locked) begin
                m_lock = bit_of(hlock, m_owner);
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge hclk) begin
        if (m_valid) begin
            chk("m_hgrant", int'(hgrant), 1 << m_owner);
            chk("m_hmaster", int'(hmaster), m_owner);
            chk("m_hmaster_d", int'(hmaster_d), m_dph);
            chk("m_hmastlock", int'(hmastlock), int'(m_lock));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset_n = 1'b0;
        hlock    = '0;
        htrans   = T_IDLE;
        hready   = 1'b1;
        tick();
        hreset_n = 1'b1;
    endtask

    task automatic dstep(input string name, input logic [1:0] tr, input logic rdy, input int exp_owner);
        htrans = tr;
        hready = rdy;
        tick();
        chk(name, int'(hmaster), exp_owner);
    endtask

    initial begin
        hreset_n = 1'b0;
        hbusreq  = '0;
        hlock    = '0;
        hprior   = '0;
        rr_mode  = 1'b0;
        htrans   = T_IDLE;
        hburst   = 3'b000;
        hready   = 1'b1;
        tick();
        tick();
        chk("rst_hgrant", int'(hgrant), 1);
        chk("rst_hmaster", int'(hmaster), 0);
        chk("rst_hmaster_d", int'(hmaster_d), 0);
        chk("rst_hmastlock", int'(hmastlock), 0);
        hreset_n = 1'b1;
        repeat (5) tick();
        chk("park_hgrant", int'(hgrant), 1);
        chk("park_hmaster_d", int'(hmaster_d), 0);

        // Priority: master 3 (prio 2) beats master 1 (prio 1).
        hbusreq = 4'b1010;
        hprior  = 8'b10_00_01_00;
        tick();
        chk("prio_hgrant", int'(hgrant), 8);
        chk("prio_hmaster", int'(hmaster), 3);
        chk("prio_hmaster_d_lag", int'(hmaster_d), 0);
        tick();
        chk("prio_hmaster_d", int'(hmaster_d), 3);

        // Round-robin among equal-priority masters 0,1,2, then fixed mode.
        do_reset();
        hbusreq = 4'b0111;
        hprior  = '0;
        rr_mode = 1'b1;
        hburst  = 3'b000;
        dstep("rr_a", T_IDLE, 1'b1, 1);
        dstep("rr_b", T_NONSEQ, 1'b1, 2);
        dstep("rr_c", T_IDLE, 1'b1, 0);
        dstep("rr_d", T_NONSEQ, 1'b1, 1);
        rr_mode = 1'b0;
        dstep("fix_a", T_IDLE, 1'b1, 0);
        dstep("fix_b", T_NONSEQ, 1'b1, 0);
        dstep("fix_c", T_IDLE, 1'b1, 0);

        // INCR8 by master 2 with BUSY and wait states; higher-priority master 0 waits.
        do_reset();
        hbusreq = 4'b0100;
        hprior  = '0;
        dstep("i8_own", T_IDLE, 1'b1, 2);
        hbusreq = 4'b0101;
        hprior  = 8'b00_00_00_11;
        hburst  = 3'b101;
        dstep("i8_b1", T_NONSEQ, 1'b1, 2);
        dstep("i8_b2", T_SEQ, 1'b1, 2);
        dstep("i8_busy1", T_BUSY, 1'b1, 2);
        dstep("i8_wait1", T_SEQ, 1'b0, 2);
        dstep("i8_b3", T_SEQ, 1'b1, 2);
        dstep("i8_wait2", T_SEQ, 1'b0, 2);
        dstep("i8_b4", T_SEQ, 1'b1, 2);
        dstep("i8_busy2", T_BUSY, 1'b1, 2);
        dstep("i8_wait3", T_SEQ, 1'b0, 2);
        dstep("i8_b5", T_SEQ, 1'b1, 2);
        dstep("i8_b6", T_SEQ, 1'b1, 2);
        dstep("i8_b7", T_SEQ, 1'b1, 2);
        dstep("i8_b8", T_SEQ, 1'b1, 0);

        // INCR hold limit of 4 beats, round-robin hand-over to master 2.
        do_reset();
        hbusreq = 4'b0010;
        hprior  = '0;
        rr_mode = 1'b1;
        hburst  = 3'b001;
        dstep("hold_own", T_IDLE, 1'b1, 1);
        hbusreq = 4'b0110;
        dstep("hold_b1", T_NONSEQ, 1'b1, 1);
        dstep("hold_b2", T_SEQ, 1'b1, 1);
        dstep("hold_b3", T_SEQ, 1'b1, 1);
        dstep("hold_b4", T_SEQ, 1'b1, 2);

        // Same with master 1 locked: limit is ignored until the lock drops.
        do_reset();
        hbusreq = 4'b0010;
        hlock   = 4'b0010;
        dstep("lk_own", T_IDLE, 1'b1, 1);
        chk("lk_hmastlock_on", int'(hmastlock), 1);
        hbusreq = 4'b0110;
        dstep("lk_b1", T_NONSEQ, 1'b1, 1);
        for (int b = 2; b <= 6; b++) dstep("lk_seq", T_SEQ, 1'b1, 1);
        chk("lk_hmastlock_hold", int'(hmastlock), 1);
        hlock = 4'b0000;
        dstep("lk_drop", T_IDLE, 1'b1, 1);
        chk("lk_hmastlock_off", int'(hmastlock), 0);
        dstep("lk_after", T_IDLE, 1'b1, 2);

        // Reset mid-INCR16 by master 3, then a fresh burst.
        do_reset();
        hbusreq = 4'b1000;
        hprior  = '0;
        rr_mode = 1'b0;
        hburst  = 3'b111;
        dstep("i16_own", T_IDLE, 1'b1, 3);
        dstep("i16_b1", T_NONSEQ, 1'b1, 3);
        dstep("i16_b2", T_SEQ, 1'b1, 3);
        dstep("i16_b3", T_SEQ, 1'b1, 3);
        hreset_n = 1'b0;
        htrans   = T_SEQ;
        tick();
        hreset_n = 1'b1;
        chk("mrst_hgrant", int'(hgrant), 1);
        chk("mrst_hmaster_d", int'(hmaster_d), 0);
        chk("mrst_hmastlock", int'(hmastlock), 0);
        dstep("i16_re", T_IDLE, 1'b1, 3);
        hbusreq = 4'b1010;
        hprior  = 8'b00_00_01_00;
        dstep("i16n_b1", T_NONSEQ, 1'b1, 3);
        for (int b = 2; b <= 16; b++) dstep("i16n_seq", T_SEQ, 1'b1, (b == 16) ? 1 : 3);

        htrans = T_IDLE;
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
